pipe_scroller: RTL and testbench

- Owns the three pipe obstacles: horizontal scrolling, respawn at the right edge, and the top-edge height of each pipe.
- Drives the 2-bit height index into the combinational height ROM and latches the 10-bit top-edge value the ROM returns.
- Detects the bird passing each pipe and keeps the score.
- Sits between the game-control FSM (start/collide/restart, frame tick) and the obstacle render/collision logic.

---
 rtl/pipe_scroller.sv | 212 +++++++++++++++++++++
 tb/tb_pipe_scroller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scroller.sv
// -----------------------------------------------------------------------------
// pipe_scroller
//   Owns the three pipe obstacles of the game. It scrolls them left on each
//   frame tick and respawns a pipe at the right once it has scrolled off. It
//   fetches each pipe's top-edge height from an external combinational ROM and
//   counts the pipes that pass the bird into a saturating score.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   frame_tick          one-cycle pulse per video frame
//   start               begin a game (accepted in IDLE only)
//   collide             level; ends the game while running
//   restart             return from DEAD to IDLE
//   seed[1:0]           first ROM index of a game, sampled on start
//   rom_y[9:0]          ROM data for rom_idx, valid in the same cycle
//   rom_idx[1:0]        registered ROM address
//   pipeK_x[10:0]       right-edge x of pipe K; pipe spans [x-PIPE_W, x)
//   pipeK_top[9:0]      latched top edge of pipe K
//   pass_pulse          one-cycle pulse when a pipe passes BIRD_X
//   score[7:0]          pipes passed, saturating at 255
//   running             high while the scene is scrolling
// -----------------------------------------------------------------------------
module pipe_scroller #(
  parameter int SCREEN_W = 640,
  parameter int PIPE_W   = 60,
  parameter int SPACING  = 240,
  parameter int SPEED    = 2,
  parameter int BIRD_X   = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        collide,
  input  logic        restart,
  input  logic [1:0]  seed,
  input  logic [9:0]  rom_y,
  output logic [1:0]  rom_idx,
  output logic [10:0] pipe0_x,
  output logic [10:0] pipe1_x,
  output logic [10:0] pipe2_x,
  output logic [9:0]  pipe0_top,
  output logic [9:0]  pipe1_top,
  output logic [9:0]  pipe2_top,
  output logic        pass_pulse,
  output logic [7:0]  score,
  output logic        running
);

  localparam logic [10:0] SPEED_X   = 11'(SPEED);
  localparam logic [11:0] SPEED_12  = 12'(SPEED);
  localparam logic [11:0] WRAP_12   = 12'(3 * SPACING);
  localparam logic [10:0] BIRD_POS  = 11'(BIRD_X);
  localparam logic [7:0]  SCORE_MAX = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD0,
    S_LOAD1,
    S_LOAD2,
    S_RUN,
    S_DEAD
  } state_e;

  state_e      state_q;
  logic [10:0] x_q       [3];
  logic [9:0]  top_q     [3];
  logic [1:0]  rom_idx_q;
  logic        pass_q;
  logic [7:0]  score_q;
  logic        running_q;

  // Scroll result for one frame tick, evaluated every cycle and only
  // committed by the FSM when a tick is accepted in RUN.
  logic [10:0] x_next_d  [3];
  logic [2:0]  respawn_d;
  logic        any_respawn_d;
  logic        any_pass_d;

  // Starting right-edge position of pipe k: just off the right of the screen,
  // each further pipe one SPACING behind the previous one.
  function automatic logic [10:0] x_init(input int k);
    return 11'(SCREEN_W + PIPE_W + k * SPACING);
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    respawn_d     = '0;
    any_respawn_d = 1'b0;
    any_pass_d    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      x_next_d[k] = x_q[k] - SPEED_X;
      // Lowest-index eligible pipe wraps; the add happens in 12 bits before
      // the subtract so a pipe at x < SPEED never goes negative.
      if (x_q[k] <= SPEED_X && !any_respawn_d) begin
        respawn_d[k]  = 1'b1;
        any_respawn_d = 1'b1;
        x_next_d[k]   = 11'((12'(x_q[k]) + WRAP_12) - SPEED_12);
      end
      // Pass test uses the plain subtracted position; a respawning pipe sits
      // left of the bird so it can never register a pass.
      if (x_q[k] > BIRD_POS && (x_q[k] - SPEED_X) <= BIRD_POS) begin
        any_pass_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rom_idx_q <= 2'd0;
      score_q   <= 8'd0;
      pass_q    <= 1'b0;
      running_q <= 1'b0;
      // NOTE: the pipe arrays are only three entries of plain flops, not a RAM,
      // so they take the asynchronous reset like every other register.
      for (int k = 0; k < 3; k++) begin
        x_q[k]   <= x_init(k);
        top_q[k] <= 10'd0;
      end
    end else begin
      // NOTE: all state updates are non-blocking so every register samples
      // the pre-edge values regardless of statement order.
      pass_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_LOAD0;
            rom_idx_q <= seed;
            score_q   <= 8'd0;
            for (int k = 0; k < 3; k++) begin
              x_q[k] <= x_init(k);
            end
          end
        end

        S_LOAD0: begin
          top_q[0]  <= rom_y;
          rom_idx_q <= rom_idx_q + 2'd1;
          state_q   <= S_LOAD1;
        end

        S_LOAD1: begin
          top_q[1]  <= rom_y;
          rom_idx_q <= rom_idx_q + 2'd1;
          state_q   <= S_LOAD2;
        end

        S_LOAD2: begin
          top_q[2]  <= rom_y;
          rom_idx_q <= rom_idx_q + 2'd1;
          state_q   <= S_RUN;
          running_q <= 1'b1;
        end

        S_RUN: begin
          // A collision in the same cycle as a tick freezes the scene first.
          if (collide) begin
            state_q   <= S_DEAD;
            running_q <= 1'b0;
          end else if (frame_tick) begin
            for (int k = 0; k < 3; k++) begin
              x_q[k] <= x_next_d[k];
              if (respawn_d[k]) begin
                top_q[k] <= rom_y;
              end
            end
            if (any_respawn_d) begin
              rom_idx_q <= rom_idx_q + 2'd1;
            end
            if (any_pass_d) begin
              pass_q <= 1'b1;
              if (score_q != SCORE_MAX) begin
                score_q <= score_q + 8'd1;
              end
            end
          end
        end

        S_DEAD: begin
          // Score stays visible in IDLE until the next start clears it.
          if (restart) begin
            state_q   <= S_IDLE;
            rom_idx_q <= 2'd0;
            for (int k = 0; k < 3; k++) begin
              x_q[k]   <= x_init(k);
              top_q[k] <= 10'd0;
            end
          end
        end

        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign rom_idx    = rom_idx_q;
  assign pipe0_x    = x_q[0];
  assign pipe1_x    = x_q[1];
  assign pipe2_x    = x_q[2];
  assign pipe0_top  = top_q[0];
  assign pipe1_top  = top_q[1];
  assign pipe2_top  = top_q[2];
  assign pass_pulse = pass_q;
  assign score      = score_q;
  assign running    = running_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// -----------------------------------------------------------------------------
// tb_pipe_scroller
//   Directed bench for pipe_scroller. Instance dut runs with default
//   parameters; instance dut_b runs with SPEED=10 so passes come every 24
//   ticks and the score can be driven to saturation quickly. Both use a
//   small ROM model returning 100/150/200/250 for indices 0..3.
// -----------------------------------------------------------------------------
module tb_pipe_scroller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A (defaults)
  logic        frame_tick, start, collide, restart;
  logic [1:0]  seed, rom_idx;
  logic [9:0]  rom_y;
  logic [10:0] pipe0_x, pipe1_x, pipe2_x;
  logic [9:0]  pipe0_top, pipe1_top, pipe2_top;
  logic        pass_pulse, running;
  logic [7:0]  score;

  // Instance B (SPEED=10)
  logic        frame_tick_b, start_b, collide_b, restart_b;
  logic [1:0]  seed_b, rom_idx_b;
  logic [9:0]  rom_y_b;
  logic [10:0] pipe0_x_b, pipe1_x_b, pipe2_x_b;
  logic [9:0]  pipe0_top_b, pipe1_top_b, pipe2_top_b;
  logic        pass_pulse_b, running_b;
  logic [7:0]  score_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic logic [9:0] rom_model(input logic [1:0] idx);
    case (idx)
      2'd0:    return 10'd100;
      2'd1:    return 10'd150;
      2'd2:    return 10'd200;
      default: return 10'd250;
    endcase
  endfunction

  assign rom_y   = rom_model(rom_idx);
  assign rom_y_b = rom_model(rom_idx_b);

  pipe_scroller dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .collide(collide), .restart(restart), .seed(seed), .rom_y(rom_y),
    .rom_idx(rom_idx), .pipe0_x(pipe0_x), .pipe1_x(pipe1_x), .pipe2_x(pipe2_x),
    .pipe0_top(pipe0_top), .pipe1_top(pipe1_top), .pipe2_top(pipe2_top),
    .pass_pulse(pass_pulse), .score(score), .running(running)
  );

  pipe_scroller #(.SPEED(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick_b), .start(start_b),
    .collide(collide_b), .restart(restart_b), .seed(seed_b), .rom_y(rom_y_b),
    .rom_idx(rom_idx_b), .pipe0_x(pipe0_x_b), .pipe1_x(pipe1_x_b),
    .pipe2_x(pipe2_x_b), .pipe0_top(pipe0_top_b), .pipe1_top(pipe1_top_b),
    .pipe2_top(pipe2_top_b), .pass_pulse(pass_pulse_b), .score(score_b),
    .running(running_b)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    frame_tick = 0; start = 0; collide = 0; restart = 0; seed = 2'd2;
    frame_tick_b = 0; start_b = 0; collide_b = 0; restart_b = 0; seed_b = 2'd0;

    // ---- Reset state ----
    cycle();
    cycle();
    check("rst_x0", pipe0_x, 700);
    check("rst_x1", pipe1_x, 940);
    check("rst_x2", pipe2_x, 1180);
    check("rst_top0", pipe0_top, 0);
    check("rst_idx", rom_idx, 0);
    check("rst_score", score, 0);
    check("rst_running", running, 0);
    rst_n = 1'b1;
    cycle();
    check("idle_hold_x0", pipe0_x, 700);

    // ---- Test 1: start with seed 2, loads ignore tick/collide/start ----
    start = 1'b1;
    cycle();
    start = 1'b1; frame_tick = 1'b1; collide = 1'b1;
    check("load_idx_seed", rom_idx, 2);
    check("load_not_running", running, 0);
    cycle(); cycle(); cycle();
    start = 1'b0; frame_tick = 1'b0; collide = 1'b0;
    check("t1_top0", pipe0_top, 200);
    check("t1_top1", pipe1_top, 250);
    check("t1_top2", pipe2_top, 100);
    check("t1_idx", rom_idx, 1);
    check("t1_running", running, 1);
    check("t1_x0", pipe0_x, 700);
    check("t1_x1", pipe1_x, 940);
    check("t1_x2", pipe2_x, 1180);

    // ---- Test 2: first pass on tick 250 ----
    repeat (249) frame();
    check("t2_x0_249", pipe0_x, 202);
    check("t2_pass_249", pass_pulse, 0);
    check("t2_score_249", score, 0);
    frame();
    check("t2_x0_250", pipe0_x, 200);
    check("t2_pass_250", pass_pulse, 1);
    check("t2_score_250", score, 1);
    check("t2_x1_250", pipe1_x, 440);
    cycle();
    check("t2_pass_drop", pass_pulse, 0);
    check("t2_no_tick_x0", pipe0_x, 200);

    // ---- Test 3: respawn on tick 350 ----
    repeat (99) frame();
    check("t3_x0_349", pipe0_x, 2);
    check("t3_idx_349", rom_idx, 1);
    frame();
    check("t3_x0_wrap", pipe0_x, 720);
    check("t3_top0", pipe0_top, 150);
    check("t3_idx", rom_idx, 2);
    check("t3_x1", pipe1_x, 240);
    check("t3_x2", pipe2_x, 480);
    check("t3_top1_kept", pipe1_top, 250);
    check("t3_score", score, 1);

    // ---- Test 4: collide wins over tick, DEAD freeze, restart ----
    frame_tick = 1'b1; collide = 1'b1;
    cycle();
    frame_tick = 1'b0; collide = 1'b0;
    check("t4_x0_frozen", pipe0_x, 720);
    check("t4_x1_frozen", pipe1_x, 240);
    check("t4_running", running, 0);
    check("t4_no_pass", pass_pulse, 0);
    repeat (5) frame();
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    check("t4_dead_x1", pipe1_x, 240);
    check("t4_dead_idx", rom_idx, 2);
    check("t4_dead_score", score, 1);
    check("t4_dead_running", running, 0);
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    check("t4_idle_x0", pipe0_x, 700);
    check("t4_idle_x1", pipe1_x, 940);
    check("t4_idle_x2", pipe2_x, 1180);
    check("t4_idle_score_held", score, 1);
    check("t4_idle_running", running, 0);

    // ---- Test 6 part 1: new game with seed 1, restart ignored in RUN ----
    seed = 2'd1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("t6_score_clr", score, 0);
    cycle(); cycle(); cycle();
    check("t6_top0", pipe0_top, 150);
    check("t6_top2", pipe2_top, 250);
    check("t6_idx", rom_idx, 0);
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    check("t6_restart_ignored", running, 1);
    repeat (10) frame();
    check("t6_x0_run", pipe0_x, 680);

    // ---- Test 6 part 2: asynchronous reset between edges ----
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_x0", pipe0_x, 700);
    check("t6_async_running", running, 0);
    check("t6_async_top0", pipe0_top, 0);
    check("t6_async_idx", rom_idx, 0);
    cycle();
    rst_n = 1'b1;
    seed = 2'd3;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle(); cycle(); cycle();
    check("t6_reload_top0", pipe0_top, 250);
    check("t6_reload_top1", pipe1_top, 100);
    check("t6_reload_idx", rom_idx, 2);

    // ---- Test 5: score saturation on instance B (tick every cycle) ----
    // Passes at ticks 50 + 24*(n-1); pass 255 lands on tick 6146.
    start_b = 1'b1;
    cycle();
    start_b = 1'b0;
    cycle(); cycle(); cycle();
    check("t5_running", running_b, 1);
    frame_tick_b = 1'b1;
    repeat (50) cycle();
    check("t5_first_pass", pass_pulse_b, 1);
    check("t5_first_x0", pipe0_x_b, 200);
    repeat (6095) cycle();
    check("t5_score_254", score_b, 254);
    cycle();
    check("t5_score_255", score_b, 255);
    check("t5_pass_255", pass_pulse_b, 1);
    repeat (23) cycle();
    check("t5_gap_pass", pass_pulse_b, 0);
    cycle();
    check("t5_sat_pass", pass_pulse_b, 1);
    check("t5_sat_score", score_b, 255);
    frame_tick_b = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
